// File: rtl/ecc_scrub_pkg.sv
// Shared types and helpers for the ECC RAM scrubber.
package ecc_scrub_pkg;

  localparam int ECC_DATA_WIDTH   = 123;
  localparam int ECC_PARITY_WIDTH = 9;

  typedef enum logic [2:0] {
    IDLE, WAIT, RD, CAP, WB, NEXT, LOCK
  } scrub_state_t;

  // Holds at max instead of wrapping; callers zero-extend to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter, cleared only by reset.
module ecc_sat_cnt
  import ecc_scrub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [31:0] MAX = 32'({WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= WIDTH'(sat_inc(32'(cnt), MAX));
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for the ECC-protected FIFO RAM: read, check, correct, log.
// Build option ECC_SCRUB_FAULT_LOCK_EN: a lockstep fault parks the FSM in LOCK until reset.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int DATA_WIDTH   = ECC_DATA_WIDTH,
  parameter int PARITY_WIDTH = ECC_PARITY_WIDTH,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int INTV_WIDTH   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scrub_en,
  input  logic [INTV_WIDTH-1:0]   scrub_intv,
  input  logic                    func_rd_req,
  input  logic                    func_wr_req,
  input  logic [ADDR_WIDTH-1:0]   func_wr_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
  output logic [DATA_WIDTH-1:0]   dec_data_in,
  output logic [PARITY_WIDTH-1:0] dec_parity_in,
  input  logic [DATA_WIDTH-1:0]   dec_data_out,
  input  logic                    dec_sbit_err,
  input  logic                    dec_dbit_err,
  input  logic                    dec_ecc_fault,
  input  logic [PARITY_WIDTH-1:0] enc_parity,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [PARITY_WIDTH-1:0] mem_wr_parity,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic [ADDR_WIDTH-1:0]   dbit_addr,
  output logic                    err_irq,
  output logic                    pass_done,
  output logic                    busy
);

  scrub_state_t state, nxt;

  logic [ADDR_WIDTH-1:0]   addr;
  logic [INTV_WIDTH-1:0]   intv_cnt;
  logic [DATA_WIDTH-1:0]   wb_data;
  logic [PARITY_WIDTH-1:0] wb_parity;
  logic wr_hit, stall, wr_match, in_word, last_addr;
  logic sbit_inc, dbit_inc, fault_inc;

  assign stall     = func_rd_req | func_wr_req;
  assign wr_match  = func_wr_req && (func_wr_addr == addr);
  assign in_word   = (state == RD) || (state == CAP) || (state == WB);
  assign last_addr = (addr == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    nxt       = state;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    sbit_inc  = 1'b0;
    dbit_inc  = 1'b0;
    fault_inc = 1'b0;
    case (state)
      IDLE: if (scrub_en) nxt = WAIT;
      WAIT: begin
        if (!scrub_en)                         nxt = IDLE;
        else if (intv_cnt <= INTV_WIDTH'(1))   nxt = RD;
      end
      RD: begin
        if (!scrub_en)   nxt = IDLE;
        else if (!stall) begin
          mem_rd_en = 1'b1;
          nxt       = CAP;
        end
      end
      CAP: begin
        if (dec_ecc_fault) begin
          fault_inc = 1'b1;
`ifdef ECC_SCRUB_FAULT_LOCK_EN
          nxt = LOCK;
`else
          nxt = NEXT;
`endif
        end else if (dec_dbit_err) begin
          dbit_inc = 1'b1;
          nxt      = NEXT;
        end else if (dec_sbit_err) begin
          sbit_inc = 1'b1;
          nxt      = WB;
        end else begin
          nxt = NEXT;
        end
      end
      WB: begin
        // A functional write to this word since RD makes the corrected copy stale.
        if (!stall) begin
          mem_wr_en = !wr_hit;
          nxt       = NEXT;
        end
      end
      NEXT: begin
        // Zero interval goes straight to RD so a clean word costs three cycles.
        if (!scrub_en)              nxt = IDLE;
        else if (scrub_intv == '0)  nxt = RD;
        else                        nxt = WAIT;
      end
      LOCK:    nxt = LOCK;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      intv_cnt  <= '0;
      wb_data   <= '0;
      wb_parity <= '0;
      wr_hit    <= 1'b0;
      dbit_addr <= '0;
      err_irq   <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      state     <= nxt;
      wr_hit    <= in_word ? (wr_hit | wr_match) : 1'b0;
      err_irq   <= (state == CAP) && (dec_ecc_fault || dec_dbit_err);
      pass_done <= (state == NEXT) && last_addr;
      case (state)
        IDLE: intv_cnt <= scrub_intv;
        WAIT: if (intv_cnt != '0) intv_cnt <= intv_cnt - INTV_WIDTH'(1);
        CAP: begin
          wb_data   <= dec_data_out;
          wb_parity <= enc_parity;
          if (!dec_ecc_fault && dec_dbit_err) dbit_addr <= addr;
        end
        NEXT: begin
          addr     <= last_addr ? '0 : addr + ADDR_WIDTH'(1);
          intv_cnt <= scrub_intv;
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_addr   = addr;
  assign mem_wr_addr   = addr;
  assign mem_wr_data   = wb_data;
  assign mem_wr_parity = wb_parity;
  assign dec_data_in   = mem_rd_data;
  assign dec_parity_in = mem_rd_parity;
  assign busy          = (state != IDLE);

  ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_sbit_cnt  (.clk(clk), .rst(rst), .inc(sbit_inc),  .cnt(sbit_cnt));
  ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_dbit_cnt  (.clk(clk), .rst(rst), .inc(dbit_inc),  .cnt(dbit_cnt));
  ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_fault_cnt (.clk(clk), .rst(rst), .inc(fault_inc), .cnt(fault_cnt));

endmodule
